// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared encodings and slot-word layout for the voice allocator
// Purpose: pipeline state codes, default sizes, slot-word field positions,
//          event FSM state type and the slot-word packing helper.
// Ports:   none (package).
package synth_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int W_DEF          = 16;

  // Per-slot pipeline state as reported back by each voice pipeline.
  typedef enum logic [1:0] {
    PS_IDLE = 2'b00,
    PS_BSY  = 2'b01,
    PS_RDY  = 2'b10
  } pipe_state_e;

  // Slot word layout: {1'b0, note[6:0], vel[7:0]}, all-zero means idle.
  localparam int VEL_LSB   = 0;
  localparam int VEL_MSB   = 7;
  localparam int NOTE_LSB  = 8;
  localparam int NOTE_MSB  = 14;
  localparam int WORD_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_GAP    = 2'd2,
    S_COMMIT = 2'd3
  } evt_state_e;

  function automatic logic [WORD_BITS-1:0] slot_word(input logic [6:0] note,
                                                     input logic [7:0] vel);
    return {1'b0, note, vel};
  endfunction

endpackage

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - sums ready voice outputs on each sample tick
// Purpose: on i_sample_tick, sign-extend and sum the signals of slots in RDY,
//          scale down by clog2(NUM_VOICES) and register the result.
// Ports:   clk, rst           - clock, synchronous active-high reset
//          i_sample_tick      - one-cycle sample strobe
//          i_voice_state      - 2 bits per slot pipeline state
//          i_voice_signal     - W bits per slot signed sample
//          o_mix, o_mix_valid - registered mix and its one-cycle valid pulse
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int W          = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_sample_tick,
  input  logic [2*NUM_VOICES-1:0] i_voice_state,
  input  logic [NUM_VOICES*W-1:0] i_voice_signal,
  output logic [W-1:0]            o_mix,
  output logic                    o_mix_valid
);

  localparam int SH = $clog2(NUM_VOICES);
  localparam int AW = W + SH;

  logic signed [AW-1:0] sum_d;
  logic [W-1:0]         mix_d;
  logic [W-1:0]         mix_q;
  logic                 mix_valid_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (i_voice_state[2*k +: 2] == PS_RDY) begin
        sum_d = sum_d + AW'($signed(i_voice_signal[W*k +: W]));
      end
    end
    // The accumulator has SH guard bits, so the scaled value always fits W.
    mix_d = W'(sum_d >>> SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= i_sample_tick;
      if (i_sample_tick) begin
        mix_q <= mix_d;
      end
    end
  end

  assign o_mix       = mix_q;
  assign o_mix_valid = mix_valid_q;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - MIDI note event to voice slot allocator with mixer
// Purpose: accepts note-on/off events, picks a slot (retrigger, free, or steal
//          oldest), drives per-slot words to the voice pipelines and mixes
//          their outputs.
// Ports:   clk, rst                        - clock, synchronous active-high reset
//          i_evt_valid/o_evt_ready         - event handshake
//          i_evt_on, i_evt_midi, i_evt_vel - event payload
//          o_voice_data, o_active          - registered slot words and busy map
//          i_voice_state, i_voice_signal   - per-slot pipeline feedback
//          i_sample_tick, o_mix, o_mix_valid - mixer strobe and result
//          o_steal                         - pulse when an active voice is stolen
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int W          = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_evt_valid,
  output logic                    o_evt_ready,
  input  logic                    i_evt_on,
  input  logic [6:0]              i_evt_midi,
  input  logic [7:0]              i_evt_vel,
  output logic [NUM_VOICES*W-1:0] o_voice_data,
  input  logic [2*NUM_VOICES-1:0] i_voice_state,
  input  logic [NUM_VOICES*W-1:0] i_voice_signal,
  input  logic                    i_sample_tick,
  output logic [W-1:0]            o_mix,
  output logic                    o_mix_valid,
  output logic [NUM_VOICES-1:0]   o_active,
  output logic                    o_steal
);

  localparam int            IW      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] AGE_MAX = IW'(NUM_VOICES - 1);

  evt_state_e              state_q, state_d;
  logic                    on_q;
  logic [6:0]              midi_q;
  logic [7:0]              vel_q;
  logic [IW-1:0]           sel_q, sel_d;
  logic                    write_q, write_d;
  logic                    steal_q, steal_d;
  logic [W-1:0]            slot_q [NUM_VOICES];
  logic [IW-1:0]           age_q  [NUM_VOICES];
  logic [NUM_VOICES*W-1:0] data_q;
  logic [NUM_VOICES-1:0]   active_q;

  logic                    match_found, free_found;
  logic [IW-1:0]           match_idx, free_idx, old_idx, old_age;

  // Descending scan so the lowest index wins every priority tie.
  always_comb begin
    match_found = 1'b0;
    free_found  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    old_idx     = '0;
    old_age     = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (slot_q[k] != '0 && slot_q[k][NOTE_MSB:NOTE_LSB] == midi_q) begin
        match_found = 1'b1;
        match_idx   = IW'(k);
      end
      if (slot_q[k] == '0) begin
        free_found = 1'b1;
        free_idx   = IW'(k);
      end
      if (age_q[k] >= old_age) begin
        old_age = age_q[k];
        old_idx = IW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    write_d = write_q;
    steal_d = steal_q;
    case (state_q)
      S_IDLE: if (i_evt_valid) state_d = S_LOOKUP;
      S_LOOKUP: begin
        write_d = 1'b1;
        steal_d = 1'b0;
        if (!on_q) begin
          sel_d   = match_idx;
          write_d = match_found;
          state_d = S_COMMIT;
        end else if (match_found) begin
          sel_d   = match_idx;
          state_d = S_GAP;
        end else if (free_found) begin
          sel_d   = free_idx;
          state_d = S_COMMIT;
        end else begin
          sel_d   = old_idx;
          steal_d = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP:    state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      on_q     <= 1'b0;
      midi_q   <= '0;
      vel_q    <= '0;
      sel_q    <= '0;
      write_q  <= 1'b0;
      steal_q  <= 1'b0;
      data_q   <= '0;
      active_q <= '0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        slot_q[k] <= '0;
        age_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      steal_q <= steal_d;
      if (o_evt_ready && i_evt_valid) begin
        // Velocity zero on a note-on is a note-off.
        on_q   <= i_evt_on && (i_evt_vel != 8'd0);
        midi_q <= i_evt_midi;
        vel_q  <= i_evt_vel;
      end
      for (int k = 0; k < NUM_VOICES; k++) begin
        // One zero cycle lets the slot's pipeline fall back to IDLE first.
        if (state_q == S_GAP && sel_q == IW'(k)) begin
          slot_q[k] <= '0;
          age_q[k]  <= '0;
        end
        if (state_q == S_COMMIT && write_q) begin
          if (sel_q == IW'(k)) begin
            slot_q[k] <= on_q ? W'(slot_word(midi_q, vel_q)) : '0;
            age_q[k]  <= '0;
          end else if (on_q && slot_q[k] != '0 && age_q[k] != AGE_MAX) begin
            age_q[k] <= age_q[k] + IW'(1);
          end
        end
        data_q[W*k +: W] <= slot_q[k];
        active_q[k]      <= (slot_q[k] != '0);
      end
    end
  end

  assign o_evt_ready  = (state_q == S_IDLE);
  assign o_steal      = (state_q == S_GAP) && steal_q;
  assign o_voice_data = data_q;
  assign o_active     = active_q;

  voice_mixer #(
    .NUM_VOICES(NUM_VOICES),
    .W         (W)
  ) u_mixer (
    .clk           (clk),
    .rst           (rst),
    .i_sample_tick (i_sample_tick),
    .i_voice_state (i_voice_state),
    .i_voice_signal(i_voice_signal),
    .o_mix         (o_mix),
    .o_mix_valid   (o_mix_valid)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_evt_valid, o_evt_ready, i_evt_on;
  logic [6:0]    i_evt_midi;
  logic [7:0]    i_evt_vel;
  logic [NV*W-1:0] o_voice_data;
  logic [2*NV-1:0] i_voice_state;
  logic [NV*W-1:0] i_voice_signal;
  logic          i_sample_tick;
  logic [W-1:0]  o_mix;
  logic          o_mix_valid;
  logic [NV-1:0] o_active;
  logic          o_steal;

  int total = 0;
  int bad   = 0;

  logic [15:0]   m_word [NV];
  int            m_age  [NV];
  logic [63:0]   h_data  [6];
  logic          h_steal [6];
  logic          h_ready [6];
  logic [3:0]    h_act   [6];

  voice_allocator #(.NUM_VOICES(NV), .W(W)) dut (
    .clk(clk), .rst(rst),
    .i_evt_valid(i_evt_valid), .o_evt_ready(o_evt_ready),
    .i_evt_on(i_evt_on), .i_evt_midi(i_evt_midi), .i_evt_vel(i_evt_vel),
    .o_voice_data(o_voice_data), .i_voice_state(i_voice_state),
    .i_voice_signal(i_voice_signal), .i_sample_tick(i_sample_tick),
    .o_mix(o_mix), .o_mix_valid(o_mix_valid),
    .o_active(o_active), .o_steal(o_steal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (one event applied atomically) --------
  task automatic model_reset;
    for (int k = 0; k < NV; k++) begin
      m_word[k] = '0;
      m_age[k]  = 0;
    end
  endtask

  task automatic model_apply(input logic on, input logic [6:0] n,
                             input logic [7:0] v, output int stole);
    int tgt;
    tgt   = -1;
    stole = 0;
    for (int k = 0; k < NV; k++)
      if (tgt < 0 && m_word[k] != 0 && m_word[k][14:8] == n) tgt = k;
    if (on && v != 0) begin
      if (tgt < 0)
        for (int k = 0; k < NV; k++) if (tgt < 0 && m_word[k] == 0) tgt = k;
      if (tgt < 0) begin
        tgt = 0;
        for (int k = 1; k < NV; k++) if (m_age[k] > m_age[tgt]) tgt = k;
        stole = 1;
      end
      for (int k = 0; k < NV; k++)
        if (k != tgt && m_word[k] != 0 && m_age[k] < NV - 1) m_age[k]++;
      m_word[tgt] = {1'b0, n, v};
      m_age[tgt]  = 0;
    end else if (tgt >= 0) begin
      m_word[tgt] = '0;
      m_age[tgt]  = 0;
    end
  endtask

  function automatic logic [63:0] model_data();
    logic [63:0] d;
    for (int k = 0; k < NV; k++) d[16*k +: 16] = m_word[k];
    return d;
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] a;
    for (int k = 0; k < NV; k++) a[k] = (m_word[k] != 0);
    return a;
  endfunction

  function automatic logic [15:0] mix_ref(input logic [7:0] st, input logic [63:0] sg);
    int s;
    s = 0;
    for (int k = 0; k < NV; k++)
      if (st[2*k +: 2] == 2'b10) s += int'($signed(sg[16*k +: 16]));
    return 16'(s >>> 2);
  endfunction

  // ---------------- stimulus helpers ---------------------------------------
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    i_evt_valid = 1'b0;
    i_sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // Sends one event; h_*[j] are sampled on the falling edge after the j-th
  // rising edge counted from the accepting edge (j = 0).
  task automatic run_evt(input logic on, input logic [6:0] n, input logic [7:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_evt_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!o_evt_ready) begin
      total++;
      bad++;
      $display("FAIL evt_ready_timeout got=%0b want=1", o_evt_ready);
    end
    i_evt_valid = 1'b1;
    i_evt_on    = on;
    i_evt_midi  = n;
    i_evt_vel   = v;
    @(negedge clk);
    i_evt_valid = 1'b0;
    i_evt_on    = 1'($urandom);
    i_evt_midi  = 7'($urandom);
    i_evt_vel   = 8'($urandom);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      h_data[j]  = o_voice_data;
      h_steal[j] = o_steal;
      h_ready[j] = o_evt_ready;
      h_act[j]   = o_active;
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    i_voice_state  = 8'hAA;
    i_voice_signal = 64'h1000_1000_1000_1000;
    i_sample_tick  = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    total++;
    if (o_mix_valid !== 1'b0 || o_mix !== 16'h0) begin
      bad++;
      $display("FAIL reset_tick_ignored got valid=%0b mix=%h want 0/0000", o_mix_valid, o_mix);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_evt_ready !== 1'b1 || o_voice_data !== 64'h0 || o_active !== 4'h0 ||
        o_steal !== 1'b0 || o_mix !== 16'h0 || o_mix_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%0b data=%h act=%b steal=%0b mix=%h mv=%0b want 1/0/0/0/0/0",
               o_evt_ready, o_voice_data, o_active, o_steal, o_mix, o_mix_valid);
    end
    i_voice_state  = '0;
    i_voice_signal = '0;
    model_reset();
  endtask

  task automatic test_note_on_basic;
    int st;
    model_apply(1'b1, 7'd60, 8'd100, st);
    run_evt(1'b1, 7'd60, 8'd100);
    total++;
    if (h_data[2] !== 64'h0) begin
      bad++;
      $display("FAIL note_on_early got=%h want=0", h_data[2]);
    end
    total++;
    if (h_data[3] !== 64'h3C64 || h_act[3] !== 4'b0001) begin
      bad++;
      $display("FAIL note_on_plus3 got data=%h act=%b want 3c64/0001", h_data[3], h_act[3]);
    end
    total++;
    if (h_ready[1] !== 1'b0 || h_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL note_on_ready got r1=%0b r2=%0b want 0/1", h_ready[1], h_ready[2]);
    end
  endtask

  task automatic test_steal;
    int st, sc;
    for (int i = 1; i < 4; i++) begin
      model_apply(1'b1, 7'(60 + i), 8'd100, st);
      run_evt(1'b1, 7'(60 + i), 8'd100);
      total++;
      if (h_data[5] !== model_data()) begin
        bad++;
        $display("FAIL fill_%0d got=%h want=%h", i, h_data[5], model_data());
      end
    end
    model_apply(1'b1, 7'd64, 8'd100, st);
    run_evt(1'b1, 7'd64, 8'd100);
    sc = 0;
    for (int j = 0; j < 6; j++) sc += int'(h_steal[j]);
    total++;
    if (sc != 1 || h_steal[1] !== 1'b1) begin
      bad++;
      $display("FAIL steal_pulse got count=%0d at1=%0b want 1/1", sc, h_steal[1]);
    end
    total++;
    if (h_data[2][15:0] !== 16'h3C64 || h_data[3][15:0] !== 16'h0 ||
        h_data[4][15:0] !== 16'h4064 || h_data[5][15:0] !== 16'h4064) begin
      bad++;
      $display("FAIL steal_slot0 got %h %h %h %h want 3c64 0000 4064 4064",
               h_data[2][15:0], h_data[3][15:0], h_data[4][15:0], h_data[5][15:0]);
    end
    total++;
    if (h_data[5] !== model_data()) begin
      bad++;
      $display("FAIL steal_others got=%h want=%h", h_data[5], model_data());
    end
  endtask

  task automatic test_retrigger;
    int st, sc;
    do_reset();
    model_apply(1'b1, 7'd60, 8'd100, st);
    run_evt(1'b1, 7'd60, 8'd100);
    model_apply(1'b1, 7'd60, 8'd50, st);
    run_evt(1'b1, 7'd60, 8'd50);
    sc = 0;
    for (int j = 0; j < 6; j++) sc += int'(h_steal[j]);
    total++;
    if (sc != 0) begin
      bad++;
      $display("FAIL retrig_no_steal got=%0d want=0", sc);
    end
    total++;
    if (h_data[2] !== 64'h3C64 || h_data[3] !== 64'h0 || h_data[4] !== 64'h3C32) begin
      bad++;
      $display("FAIL retrig_gap got %h %h %h want 3c64 0 3c32", h_data[2], h_data[3], h_data[4]);
    end
  endtask

  task automatic test_note_off;
    int st, changes;
    model_apply(1'b0, 7'd61, 8'd40, st);
    run_evt(1'b0, 7'd61, 8'd40);
    changes = 0;
    for (int j = 0; j < 6; j++) if (h_data[j] !== 64'h3C32) changes++;
    total++;
    if (changes != 0) begin
      bad++;
      $display("FAIL off_nomatch got changes=%0d last=%h want 0/3c32", changes, h_data[5]);
    end
    total++;
    if (h_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL off_nomatch_done got=%0b want=1", h_ready[2]);
    end
    model_apply(1'b1, 7'd60, 8'd0, st);
    run_evt(1'b1, 7'd60, 8'd0);
    total++;
    if (h_data[2] !== 64'h3C32 || h_data[3] !== 64'h0 || h_act[3] !== 4'b0000) begin
      bad++;
      $display("FAIL vel0_off got %h %h act=%b want 3c32 0 0000", h_data[2], h_data[3], h_act[3]);
    end
  endtask

  task automatic test_mixer_directed;
    @(negedge clk);
    i_voice_state  = {2'b00, 2'b01, 2'b10, 2'b10};
    i_voice_signal = 64'h7FFF_7FFF_4000_4000;
    i_sample_tick  = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    total++;
    if (o_mix !== 16'h2000 || o_mix_valid !== 1'b1) begin
      bad++;
      $display("FAIL mix_directed got mix=%h v=%0b want 2000/1", o_mix, o_mix_valid);
    end
    @(negedge clk);
    total++;
    if (o_mix_valid !== 1'b0 || o_mix !== 16'h2000) begin
      bad++;
      $display("FAIL mix_pulse got mix=%h v=%0b want 2000/0", o_mix, o_mix_valid);
    end
  endtask

  task automatic test_mixer_random;
    logic [15:0] exp_mix;
    exp_mix = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (o_mix !== exp_mix || o_mix_valid !== 1'b1) begin
          bad++;
          $display("FAIL mix_rand_%0d got mix=%h v=%0b want %h/1", i, o_mix, o_mix_valid, exp_mix);
        end
      end
      i_voice_state  = 8'($urandom);
      i_voice_signal = {$urandom, $urandom};
      i_sample_tick  = 1'b1;
      exp_mix = mix_ref(i_voice_state, i_voice_signal);
    end
    @(negedge clk);
    i_sample_tick = 1'b0;
    total++;
    if (o_mix !== exp_mix || o_mix_valid !== 1'b1) begin
      bad++;
      $display("FAIL mix_rand_last got mix=%h v=%0b want %h/1", o_mix, o_mix_valid, exp_mix);
    end
  endtask

  task automatic test_tick_during_event;
    int st;
    logic [15:0] exp_mix;
    do_reset();
    model_apply(1'b1, 7'd70, 8'd33, st);
    @(negedge clk);
    i_evt_valid = 1'b1;
    i_evt_on    = 1'b1;
    i_evt_midi  = 7'd70;
    i_evt_vel   = 8'd33;
    for (int j = 0; j < 4; j++) begin
      i_voice_state  = 8'($urandom);
      i_voice_signal = {$urandom, $urandom};
      i_sample_tick  = 1'b1;
      exp_mix = mix_ref(i_voice_state, i_voice_signal);
      @(negedge clk);
      i_evt_valid = 1'b0;
      total++;
      if (o_mix !== exp_mix || o_mix_valid !== 1'b1) begin
        bad++;
        $display("FAIL tick_in_fsm_%0d got mix=%h v=%0b want %h/1", j, o_mix, o_mix_valid, exp_mix);
      end
    end
    i_sample_tick = 1'b0;
    @(negedge clk);
    total++;
    if (o_voice_data !== model_data() || o_evt_ready !== 1'b1) begin
      bad++;
      $display("FAIL tick_in_fsm_evt got data=%h rdy=%0b want %h/1", o_voice_data, o_evt_ready, model_data());
    end
  endtask

  task automatic test_random_events;
    int st, sc;
    logic on;
    logic [6:0] n;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      on = ($urandom_range(0, 9) < 7);
      n  = 7'(60 + $urandom_range(0, 7));
      v  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      model_apply(on, n, v, st);
      run_evt(on, n, v);
      sc = 0;
      for (int j = 0; j < 6; j++) sc += int'(h_steal[j]);
      total++;
      if (h_data[5] !== model_data() || h_act[5] !== model_active()) begin
        bad++;
        $display("FAIL rand_evt_%0d got data=%h act=%b want %h/%b",
                 i, h_data[5], h_act[5], model_data(), model_active());
      end
      total++;
      if (sc != st) begin
        bad++;
        $display("FAIL rand_steal_%0d got=%0d want=%0d", i, sc, st);
      end
    end
  endtask

  task automatic test_reset_in_gap;
    int st, sc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      model_apply(1'b1, 7'(60 + i), 8'd100, st);
      run_evt(1'b1, 7'(60 + i), 8'd100);
    end
    @(negedge clk);
    i_evt_valid = 1'b1;
    i_evt_on    = 1'b1;
    i_evt_midi  = 7'd64;
    i_evt_vel   = 8'd100;
    @(negedge clk);
    i_evt_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_steal !== 1'b1) begin
      bad++;
      $display("FAIL gap_steal_seen got=%0b want=1", o_steal);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_evt_ready !== 1'b1 || o_voice_data !== 64'h0 || o_active !== 4'h0) begin
      bad++;
      $display("FAIL gap_reset got rdy=%0b data=%h act=%b want 1/0/0", o_evt_ready, o_voice_data, o_active);
    end
    sc = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sc += int'(o_steal);
    end
    total++;
    if (sc != 0 || o_voice_data !== 64'h0) begin
      bad++;
      $display("FAIL gap_after got steals=%0d data=%h want 0/0", sc, o_voice_data);
    end
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    i_evt_valid = 1'b0;
    i_evt_on = 1'b0;
    i_evt_midi = '0;
    i_evt_vel = '0;
    i_voice_state = '0;
    i_voice_signal = '0;
    i_sample_tick = 1'b0;
    test_reset();
    test_note_on_basic();
    test_steal();
    test_retrigger();
    test_note_off();
    test_mixer_directed();
    test_mixer_random();
    test_tick_during_event();
    test_random_events();
    test_reset_in_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of pipeline slots driven.
REQ-002 SHALL have parameter W, default 16, pipeline data and signal width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port i_evt_valid  in  1  MIDI event offered.
REQ-006 SHALL have port o_evt_ready  out  1  event accepted when valid&ready at clk edge.
REQ-007 SHALL have port i_evt_on  in  1  1 = note-on, 0 = note-off.
REQ-008 SHALL have port i_evt_midi  in  7  note number.
REQ-009 SHALL have port i_evt_vel  in  8  velocity.
REQ-010 SHALL have port o_voice_data  out  NUM_VOICES*W  per-slot word; slot k at [W*k+W-1:W*k], format {1'b0, note[6:0], vel[7:0]}, all-zero = idle.
REQ-011 SHALL have port i_voice_state  in  2*NUM_VOICES  per-slot pipeline state; 00 IDLE, 01 BSY, 10 RDY.
REQ-012 SHALL have port i_voice_signal  in  NUM_VOICES*W  per-slot signed pipeline output.
REQ-013 SHALL have port i_sample_tick  in  1  one-cycle sample-rate strobe.
REQ-014 SHALL have port o_mix  out  W  signed mixed sample.
REQ-015 SHALL have port o_mix_valid  out  1  one-cycle pulse, o_mix updated.
REQ-016 SHALL have port o_active  out  NUM_VOICES  bitmap of non-zero slots.
REQ-017 SHALL have port o_steal  out  1  one-cycle pulse when an active voice is stolen.

Function
REQ-018 Event FSM SHALL have states S_IDLE, S_LOOKUP, S_GAP, S_COMMIT; o_evt_ready = 1 only in S_IDLE.
REQ-019 Acceptance SHALL latch on/midi/vel and move S_IDLE -> S_LOOKUP.
REQ-020 Note-on with vel = 0 SHALL be handled as note-off.
REQ-021 S_LOOKUP note-on slot choice, in priority: active slot with same note (retrigger); else lowest-index zero slot; else slot with largest age (steal, lowest index on tie).
REQ-022 Retrigger or steal SHALL go S_LOOKUP -> S_GAP, writing slot to zero for exactly one cycle so the pipeline returns to IDLE; free slot SHALL go directly to S_COMMIT.
REQ-023 S_COMMIT SHALL write the slot word; visible on o_voice_data 3 cycles after acceptance (free slot) or 4 cycles (retrigger/steal); FSM then returns to S_IDLE.
REQ-024 o_steal SHALL pulse in the S_GAP cycle of a steal only, not of a retrigger.
REQ-025 Note-off SHALL zero the matching active slot in S_COMMIT; no match -> no slot change, FSM still completes S_LOOKUP -> S_COMMIT -> S_IDLE.
REQ-026 Per-slot age (clog2(NUM_VOICES) bits): written slot reset to 0; every other active slot incremented, saturating at NUM_VOICES-1; zeroed slots reset to 0.
REQ-027 On i_sample_tick, mixer SHALL sum sign-extended i_voice_signal of slots whose state = RDY into W+clog2(NUM_VOICES)-bit accumulator; non-RDY slots contribute 0.
REQ-028 o_mix SHALL be the sum arithmetic-shifted right by clog2(NUM_VOICES), registered; o_mix_valid pulses the cycle after the tick.
REQ-029 Mixer and event FSM SHALL be independent; a tick during any FSM state SHALL be served without stalling either.
REQ-030 o_active[k] SHALL equal (slot word k != 0), registered with the slot word.

Reset
REQ-031 rst SHALL force: FSM S_IDLE, all slot words 0, ages 0, o_mix 0, o_mix_valid 0, o_steal 0, o_active 0; o_evt_ready = 1 the cycle after rst deasserts.
REQ-032 Event in flight at rst SHALL be discarded; tick coincident with rst SHALL be ignored.

Structure
REQ-033 Shared package synth_pkg SHALL hold pipeline state encodings (IDLE/BSY/RDY), NUM_VOICES default, W and slot-word field positions.
REQ-034 Mixer SHALL be sub-module voice_mixer (tick, state, signals -> o_mix, o_mix_valid).

Verification
REQ-035 Note-on 60/vel 100 after reset -> slot 0 = 16'h3C64 at cycle +3, o_active = 0001.
REQ-036 Five distinct note-ons (60..64) -> fifth steals slot 0 (oldest): slot 0 zero one cycle, then 16'h4064, o_steal one pulse.
REQ-037 Note-on 60 twice (vel 100, then 50) -> same slot, one-cycle zero gap, then 16'h3C32, o_steal = 0.
REQ-038 Note-off 61 with no match -> no o_voice_data change; note-on 60 vel 0 while 60 active -> slot zeroed.
REQ-039 States RDY,RDY,BSY,IDLE with signals 16'h4000,16'h4000,16'h7FFF,16'h7FFF, tick -> next cycle o_mix = 16'h2000, o_mix_valid = 1.
REQ-040 rst asserted in S_GAP -> all slots 0, o_evt_ready = 1 after release, no o_steal pulse afterwards.
